// File: rtl/iot_tx.sv
// iot_tx: word FIFO feeding a byte serializer (MSB byte first) with busy backpressure.
// Optional sent-word counter enabled by macro IOT_TX_SENT_CNT_EN.
module iot_tx #(
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en,
  input  logic [127:0] wr_data,
  output logic         full,
  input  logic         busy,
  output logic         in_en,
  output logic [7:0]   iot_in,
  output logic         idle,
  output logic [15:0]  sent_cnt
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic {IDLE, SEND} state_t;
  state_t state, state_nx;
  logic [127:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt, cnt_nx;
  logic [3:0] idx, idx_nx;
  logic push, drive, pop;
  logic [127:0] head;
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = state == IDLE ? (cnt != '0 ? SEND : IDLE) : (pop && cnt_nx == '0 ? IDLE : SEND);
  always_comb begin
    push = wr_en && !full;
    drive = state == SEND && !busy;
    pop = drive && idx == 4'd15;
    idx_nx = drive ? idx + 4'd1 : idx;
    cnt_nx = cnt + (AW+1)'(push) - (AW+1)'(pop);
    head = mem[rp];
  end
  always_ff @(posedge clk)
    if (push && !rst) mem[wp] <= wr_data;
  always_ff @(posedge clk)
    if (rst) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      idx <= '0;
      full <= 1'b0;
      idle <= 1'b1;
      in_en <= 1'b0;
      iot_in <= 8'h00;
    end else begin
      wp <= push ? wp + AW'(1) : wp;
      rp <= pop ? rp + AW'(1) : rp;
      cnt <= cnt_nx;
      idx <= idx_nx;
      full <= cnt_nx == (AW+1)'(DEPTH);
      idle <= cnt_nx == '0 && idx_nx == 4'd0;
      in_en <= drive;
      iot_in <= drive ? head[{~idx, 3'b111} -: 8] : 8'h00;
    end
`ifdef IOT_TX_SENT_CNT_EN
  always_ff @(posedge clk)
    if (rst) sent_cnt <= '0;
    else if (pop) sent_cnt <= sent_cnt + 16'd1;
`else
  assign sent_cnt = 16'h0000;
`endif
endmodule

// File: tb/tb_iot_tx.sv
// tb_iot_tx: directed and randomized checks of iot_tx against a queue-based model.
module tb_iot_tx;
  localparam int DEPTH = 4;
  logic clk = 1'b0, rst = 1'b0, wr_en = 1'b0, busy = 1'b0;
  logic [127:0] wr_data = '0;
  logic full, in_en, idle;
  logic [7:0] iot_in;
  logic [15:0] sent_cnt;
  int checks = 0, failures = 0;
  logic [127:0] q[$];
  logic [7:0] out_q[$];
  int m_idx = 0;
  bit m_act = 0;
  logic [15:0] m_cnt = 0;

  iot_tx #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .full(full),
    .busy(busy), .in_en(in_en), .iot_in(iot_in), .idle(idle), .sent_cnt(sent_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input bit r, input bit w, input logic [127:0] d, input bit b);
    bit drv, popped, was_ne, full_pre;
    logic [7:0] eb;
    logic [127:0] h;
    logic [15:0] ecnt;
    rst = r; wr_en = w; wr_data = d; busy = b;
    @(posedge clk);
    #1;
    drv = 0; eb = 8'h00; popped = 0;
    if (r) begin
      q.delete(); m_idx = 0; m_act = 0; m_cnt = 0;
    end else begin
      was_ne = q.size() != 0;
      full_pre = q.size() == DEPTH;
      drv = m_act && !b;
      if (drv) begin
        h = q[0];
        eb = 8'(h >> (8 * (15 - m_idx)));
        m_idx++;
        if (m_idx == 16) begin
          void'(q.pop_front());
          m_idx = 0; m_cnt++; popped = 1;
        end
      end
      if (w && !full_pre) q.push_back(d);
      m_act = m_act ? !(popped && q.size() == 0) : was_ne;
    end
    if (drv) out_q.push_back(eb);
`ifdef IOT_TX_SENT_CNT_EN
    ecnt = m_cnt;
`else
    ecnt = 16'h0000;
`endif
    chk("in_en", 16'(in_en), 16'(drv));
    chk("iot_in", 16'(iot_in), 16'(eb));
    chk("full", 16'(full), 16'(q.size() == DEPTH));
    chk("idle", 16'(idle), 16'(q.size() == 0 && m_idx == 0));
    chk("sent_cnt", sent_cnt, ecnt);
  endtask

  task automatic run_until_idle(input int limit);
    int n = 0;
    while (!(q.size() == 0 && m_idx == 0) && n < limit) begin
      step(0, 0, '0, 0);
      n++;
    end
    chk("drain_timeout", 16'(n < limit), 16'd1);
  endtask

  initial begin
    logic [127:0] w0;
    int n;
    step(1, 0, '0, 0);
    step(1, 1, {16{8'h55}}, 1);
    // single ascending word
    for (int j = 0; j < 16; j++) w0[127 - 8*j -: 8] = 8'(j);
    out_q.delete();
    step(0, 1, w0, 0);
    run_until_idle(40);
    chk("w0_len", 16'(out_q.size()), 16'd16);
    for (int j = 0; j < 16 && j < out_q.size(); j++) chk("w0_byte", 16'(out_q[j]), 16'(j));
    // backpressure after byte 4
    out_q.delete();
    step(0, 1, {16{8'hAA}}, 0);
    n = 0;
    while (m_idx != 5 && n < 40) begin step(0, 0, '0, 0); n++; end
    chk("bp_reach", 16'(m_idx), 16'd5);
    for (int k = 0; k < 3; k++) step(0, 0, '0, 1);
    run_until_idle(40);
    chk("bp_len", 16'(out_q.size()), 16'd16);
    // back-to-back fill plus ignored 5th push
    out_q.delete();
    for (int k = 0; k < 5; k++) step(0, 1, {$urandom, $urandom, $urandom, $urandom}, 0);
    chk("b2b_full_drop", 16'(q.size()), 16'd4);
    run_until_idle(120);
    chk("b2b_len", 16'(out_q.size()), 16'd64);
    // full FIFO with push at the byte-15 edge
    for (int k = 0; k < 4; k++) step(0, 1, {$urandom, $urandom, $urandom, $urandom}, 1);
    n = 0;
    while (m_idx != 15 && n < 40) begin step(0, 0, '0, 0); n++; end
    step(0, 1, {16{8'hEE}}, 0);
    chk("fp_remain", 16'(q.size()), 16'd3);
    run_until_idle(100);
    // reset mid-word
    step(0, 1, {$urandom, $urandom, $urandom, $urandom}, 0);
    step(0, 1, {$urandom, $urandom, $urandom, $urandom}, 0);
    n = 0;
    while (m_idx != 8 && n < 40) begin step(0, 0, '0, 0); n++; end
    step(1, 1, {16{8'h77}}, 0);
    out_q.delete();
    step(0, 1, w0, 0);
    run_until_idle(40);
    chk("rst_restart_len", 16'(out_q.size()), 16'd16);
    if (out_q.size() > 0) chk("rst_restart_b0", 16'(out_q[0]), 16'h00);
    // randomized traffic, then drain
    for (int k = 0; k < 4000; k++)
      step($urandom_range(0, 299) == 0, $urandom_range(0, 5) < 2,
           {$urandom, $urandom, $urandom, $urandom}, $urandom_range(0, 3) == 0);
    run_until_idle(200);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/iot_tx.md
IOT_TX -- requirements
Module: iot_tx

Interface
REQ-001 Parameter: DEPTH, default 4, word-FIFO depth in 128-bit words; a power of two, 2 to 16.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 wr_en  input  1  push wr_data into the word FIFO at this edge.
REQ-005 wr_data  input  128  word to transmit, byte 0 = bits [127:120].
REQ-006 full  output  1  FIFO holds DEPTH words; registered.
REQ-007 busy  input  1  backpressure from the IOTDF data filter.
REQ-008 in_en  output  1  iot_in carries a valid byte this cycle; registered.
REQ-009 iot_in  output  8  serialized data byte; registered.
REQ-010 idle  output  1  FIFO empty and no word partially sent; registered.
REQ-011 sent_cnt  output  16  count of fully sent words (see Configuration).

Function
REQ-012 Each word SHALL be sent as 16 bytes, MSB first: byte j = wr_data[127-8j -: 8], j = 0..15.
REQ-013 Two states, IDLE and SEND; IDLE -> SEND at an edge where the FIFO is non-empty; SEND -> IDLE after byte 15 is driven while the FIFO becomes empty.
REQ-014 At each edge in SEND with busy=0, the block SHALL register in_en=1 and the current byte, then advance the byte index.
REQ-015 At each edge with busy=1, or in IDLE, the block SHALL register in_en=0 and iot_in=8'h00; the byte index SHALL hold.
REQ-016 A byte, once driven with in_en=1, is consumed; it SHALL NOT be repeated, even if busy rises during that cycle.
REQ-017 When byte 15 is driven, the head word SHALL be popped and the index wrapped to 0.
REQ-018 If the FIFO is still non-empty after a pop, byte 0 of the next word SHALL be driven at the very next edge with busy=0, with no gap cycle.
REQ-019 A word pushed into an empty FIFO at edge t SHALL have byte 0 driven no earlier than edge t+1.
REQ-020 wr_en while full=1 SHALL be ignored and the FIFO left unchanged, even if a pop occurs at the same edge.
REQ-021 A simultaneous push and pop on a non-full FIFO SHALL leave the occupancy unchanged; FIFO pointers SHALL wrap modulo DEPTH.
REQ-022 full SHALL assert at the edge occupancy reaches DEPTH and deassert at the edge of the first pop.
REQ-023 idle SHALL be 1 exactly when the FIFO is empty and the byte index is 0.

Reset
REQ-024 At an edge with rst=1, the block SHALL set in_en=0, iot_in=8'h00, full=0, idle=1 and sent_cnt=0, discard all FIFO contents, clear the byte index, and enter IDLE.
REQ-025 Reset mid-word SHALL abandon the partial word; no remaining bytes of it SHALL be driven after reset.
REQ-026 rst SHALL take priority over wr_en and busy at the same edge.

Configuration
REQ-027 Macro IOT_TX_SENT_CNT_EN: when defined, sent_cnt SHALL increment by 1 at each pop (REQ-017) and wrap from 16'hFFFF to 0.
REQ-028 Without IOT_TX_SENT_CNT_EN, sent_cnt SHALL be constant 16'h0000, no counter flops SHALL exist, and the port list SHALL be unchanged.

Verification
REQ-029 Single word: push 128'h000102...0F with busy=0 -> in_en high for 16 consecutive cycles, iot_in = 00,01,...,0F; idle=1 after.
REQ-030 Backpressure: hold busy=1 for 3 edges after byte 4 of word AA..AA (16 bytes of AA) -> in_en=0 and iot_in=00 for those 3 cycles; sending resumes with byte 5; all 16 bytes are delivered exactly once.
REQ-031 Back-to-back: push 4 words on consecutive edges with DEPTH=4 -> full=1 after the 4th push; a 5th push is ignored; 64 contiguous bytes are sent with no gaps.
REQ-032 Full plus pop: with the FIFO full, push at the same edge byte 15 is driven -> the push is dropped; full=0 next cycle; 3 words remain.
REQ-033 Reset mid-word: rst=1 after byte 7 of word 1 -> the next cycle shows in_en=0, idle=1, full=0; a word pushed after reset starts at byte 0.
REQ-034 With IOT_TX_SENT_CNT_EN: send 96 words -> sent_cnt=96; without the macro -> sent_cnt stays 0 throughout.
